// File: rtl/generador_aleatorio_rango.sv
// Bounded random draws from a free-running Galois LFSR, handed out through a
// req/valid handshake with rejection sampling and a deterministic fallback.
module generador_aleatorio_rango #(
    parameter int               WIDTH     = 8,
    parameter int               OUT_W     = 3,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter int               MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load_seed,
    input  logic             req,
    input  logic [OUT_W-1:0] limite,
    input  logic             no_repeat,
    output logic [OUT_W-1:0] rnd,
    output logic             valid,
    output logic             busy,
    output logic             fallback
);

    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0] lim_q, lim_d;
    logic             nr_q, nr_d;
    logic [OUT_W-1:0] rnd_q, rnd_d;
    logic             valid_q, valid_d;
    logic             fallback_q, fallback_d;
    logic [OUT_W-1:0] last_q, last_d;
    logic             have_last_q, have_last_d;

    logic [OUT_W-1:0] cand;
    logic             accept;
    logic [OUT_W:0]   fb_wide;
    logic [OUT_W-1:0] fb_val;

    // Candidate is the pre-edge LFSR value; the fallback walks upward from
    // the last handed-out value so it never repeats it unless forced to 0.
    assign cand    = lfsr_q[OUT_W-1:0];
    assign accept  = ((lim_q == '0) || (cand < lim_q)) &&
                     !(nr_q && have_last_q && (cand == last_q));
    assign fb_wide = have_last_q ? ({1'b0, last_q} + (OUT_W+1)'(1)) : '0;
    assign fb_val  = (fb_wide[OUT_W] || ((lim_q != '0) && (fb_wide >= {1'b0, lim_q})))
                     ? '0 : fb_wide[OUT_W-1:0];

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d     = state_q;
        tries_d     = tries_q;
        lim_d       = lim_q;
        nr_d        = nr_q;
        rnd_d       = rnd_q;
        valid_d     = 1'b0;
        fallback_d  = fallback_q;
        last_d      = last_q;
        have_last_d = have_last_q;

        if (load_seed) begin
            lfsr_d = (seed == '0) ? WIDTH'(1) : seed;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    lim_d   = limite;
                    nr_d    = no_repeat;
                    tries_d = '0;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (accept) begin
                    rnd_d       = cand;
                    last_d      = cand;
                    have_last_d = 1'b1;
                    valid_d     = 1'b1;
                    fallback_d  = 1'b0;
                    state_d     = IDLE;
                end else if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                    rnd_d       = fb_val;
                    last_d      = fb_val;
                    have_last_d = 1'b1;
                    valid_d     = 1'b1;
                    fallback_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tries_d = tries_q + TRY_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lfsr_q      <= WIDTH'(1);
            tries_q     <= '0;
            lim_q       <= '0;
            nr_q        <= 1'b0;
            rnd_q       <= '0;
            valid_q     <= 1'b0;
            fallback_q  <= 1'b0;
            last_q      <= '0;
            have_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tries_q     <= tries_d;
            lim_q       <= lim_d;
            nr_q        <= nr_d;
            rnd_q       <= rnd_d;
            valid_q     <= valid_d;
            fallback_q  <= fallback_d;
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end

    assign rnd      = rnd_q;
    assign valid    = valid_q;
    assign busy     = (state_q == DRAW);
    assign fallback = fallback_q;

endmodule

// File: tb/tb_generador_aleatorio_rango.sv
// Self-checking bench: a cycle-level behavioural model of the draw rules is
// compared every cycle, plus literal expectations for the known sequences.
module tb_generador_aleatorio_rango;

    localparam int WIDTH     = 8;
    localparam int OUT_W     = 3;
    localparam int TAPS_I    = 'hB8;
    localparam int MAX_TRIES = 16;
    localparam int OUT_RANGE = 1 << OUT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] seed = '0;
    logic             load_seed = 1'b0;
    logic             req = 1'b0;
    logic [OUT_W-1:0] limite = '0;
    logic             no_repeat = 1'b0;
    logic [OUT_W-1:0] rnd;
    logic             valid;
    logic             busy;
    logic             fallback;

    int n_tests = 0;
    int n_fail  = 0;

    generador_aleatorio_rango #(
        .WIDTH    (WIDTH),
        .OUT_W    (OUT_W),
        .TAPS     (8'hB8),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seed     (seed),
        .load_seed(load_seed),
        .req      (req),
        .limite   (limite),
        .no_repeat(no_repeat),
        .rnd      (rnd),
        .valid    (valid),
        .busy     (busy),
        .fallback (fallback)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bound is the effective range size, a draw is just
    // "remaining candidates" plus the accept rule and fallback arithmetic.
    int m_lfsr, m_rnd, m_last, m_bound, m_tries;
    bit m_valid, m_busy, m_fb, m_have, m_nr;
    int t_cand, t_next, t_fbv;
    bit t_ok;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr = 1; m_busy = 0; m_valid = 0; m_rnd = 0; m_fb = 0;
            m_last = 0; m_have = 0; m_tries = 0; m_bound = OUT_RANGE; m_nr = 0;
        end else begin
            t_cand = m_lfsr % OUT_RANGE;
            if (load_seed)       t_next = (seed == 0) ? 1 : int'(seed);
            else if (m_lfsr % 2) t_next = (m_lfsr / 2) ^ TAPS_I;
            else                 t_next = m_lfsr / 2;
            m_valid = 0;
            if (!m_busy) begin
                if (req) begin
                    m_busy  = 1;
                    m_bound = (limite == 0) ? OUT_RANGE : int'(limite);
                    m_nr    = no_repeat;
                    m_tries = 0;
                end
            end else begin
                t_ok = (t_cand < m_bound) && !(m_nr && m_have && t_cand == m_last);
                if (t_ok) begin
                    m_rnd = t_cand; m_last = t_cand; m_have = 1;
                    m_valid = 1; m_fb = 0; m_busy = 0;
                end else if (m_tries == MAX_TRIES - 1) begin
                    t_fbv = m_have ? m_last + 1 : 0;
                    if (t_fbv >= m_bound) t_fbv = 0;
                    m_rnd = t_fbv; m_last = t_fbv; m_have = 1;
                    m_valid = 1; m_fb = 1; m_busy = 0;
                end else begin
                    m_tries++;
                end
            end
            m_lfsr = t_next;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("model_rnd", int'(rnd), m_rnd);
            check("model_valid", int'(valid), int'(m_valid));
            check("model_busy", int'(busy), int'(m_busy));
            check("model_fallback", int'(fallback), int'(m_fb));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s);
        load_seed = 1'b1;
        seed      = WIDTH'(s);
        tick();
        load_seed = 1'b0;
    endtask

    task automatic do_draw(input int lim, input bit nr, output int r, output int f, output int edges);
        bit got;
        req       = 1'b1;
        limite    = OUT_W'(lim);
        no_repeat = nr;
        tick();
        req   = 1'b0;
        got   = 0;
        edges = 0;
        r     = -1;
        f     = -1;
        for (int i = 0; i < MAX_TRIES + 4 && !got; i++) begin
            tick();
            edges++;
            if (valid) begin
                got = 1;
                r   = int'(rnd);
                f   = int'(fallback);
            end
        end
        if (!got) check("draw_timeout", edges, -1);
    endtask

    task automatic wait_valid(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < MAX_TRIES + 4 && !got; i++) begin
            tick();
            if (valid) got = 1;
        end
        if (!got) check(name, 0, 1);
    endtask

    int r, f, e, nvalid, first_r;
    bit varied;

    initial begin
        #1 rst = 1'b0;
        #2;
        check("reset_rnd", int'(rnd), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_fallback", int'(fallback), 0);
        #10 rst = 1'b1;
        tick();

        // Seed sequence
        load(0);
        do_draw(0, 0, r, f, e);
        check("s1_rnd0", r, 0); check("s1_fb0", f, 0); check("s1_lat", e, 1);
        do_draw(0, 0, r, f, e);
        check("s1_rnd1", r, 6); check("s1_lat1", e, 1);

        // Rejection of 4,6,7,3 under limite=3
        load(0);
        tick();
        do_draw(3, 0, r, f, e);
        check("s2_rnd", r, 1); check("s2_fb", f, 0); check("s2_lat", e, 5);

        // No-repeat fallback after an accepted 0
        load(0);
        do_draw(0, 0, r, f, e);
        check("s3_pre", r, 0);
        do_draw(1, 1, r, f, e);
        check("s3_lat", e, MAX_TRIES); check("s3_fb", f, 1); check("s3_rnd", r, 0);

        // Request while busy is ignored
        load(0);
        tick();
        req = 1'b1; limite = 3'd3; no_repeat = 1'b0;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_valid("s4_wait");
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (valid) nvalid++;
        end
        check("s4_no_extra_valid", nvalid, 0);

        // Seed reload in the middle of a draw
        req = 1'b1; limite = 3'd1; no_repeat = 1'b0;
        tick();
        req = 1'b0;
        load(0);
        wait_valid("s4_seed_wait");
        check("s4_seed_rnd", int'(rnd), 0);
        check("s4_seed_fb", int'(fallback), 0);

        // Async reset between edges while busy
        load(0);
        tick();
        req = 1'b1; limite = 3'd3;
        tick();
        req = 1'b0;
        tick();
        #2 rst = 1'b0;
        #1;
        check("s5_busy", int'(busy), 0);
        check("s5_valid", int'(valid), 0);
        check("s5_rnd", int'(rnd), 0);
        check("s5_fallback", int'(fallback), 0);
        req = 1'b1; limite = 3'd0; no_repeat = 1'b0;
        #1 rst = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("s5_first_valid", int'(valid), 1);
        check("s5_first_rnd", int'(rnd), 0);
        do_draw(0, 0, r, f, e);
        check("s5_second_rnd", r, 6);

        // Zero seed guard, full range
        load(0);
        varied = 0;
        first_r = -1;
        for (int i = 0; i < 20; i++) begin
            do_draw(0, 0, r, f, e);
            check("s6_fb", f, 0);
            check("s6_lat", e, 1);
            if (i == 0) first_r = r;
            else if (r != first_r) varied = 1;
        end
        check("s6_varied", int'(varied), 1);

        // Randomized traffic checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            req       = ($urandom_range(0, 2) != 0);
            limite    = OUT_W'($urandom_range(0, OUT_RANGE - 1));
            no_repeat = ($urandom_range(0, 1) == 1);
            load_seed = ($urandom_range(0, 30) == 0);
            seed      = WIDTH'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 255));
            tick();
        end
        req = 1'b0;
        load_seed = 1'b0;
        for (int i = 0; i < MAX_TRIES + 2; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/generador_aleatorio_rango.md
Name: generador_aleatorio_rango

Overview:
- Parametrised successor to the team's 3-bit seeded random generator.
- Uses a Galois LFSR of configurable width and polynomial. Hands out bounded random draws (0..limite-1) through a req/valid handshake, with an optional no-consecutive-repeat mode.
- Runtime seed loading; rejection sampling with a bounded retry count and a deterministic fallback.
- Feeds game-logic blocks: piece placement, turn order, AI moves.

Parameters:
- WIDTH, 8: LFSR width in bits (4..16).
- OUT_W, 3: output width in bits; OUT_W <= WIDTH.
- TAPS, 8'hB8: Galois feedback mask, WIDTH bits; bit WIDTH-1 must be 1.
- MAX_TRIES, 16: maximum candidates evaluated per draw (>= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset (0 = reset).
- seed  in  WIDTH  seed value.
- load_seed  in  1  synchronous seed load strobe.
- req  in  1  draw request, sampled only in IDLE.
- limite  in  OUT_W  exclusive upper bound; 0 means full range 2^OUT_W.
- no_repeat  in  1  forbid returning the previous accepted value.
- rnd  out  OUT_W  drawn value; held until the next accepted draw.
- valid  out  1  one-cycle pulse when rnd updates.
- busy  out  1  draw in progress.
- fallback  out  1  registered with valid; 1 = value came from the fallback path.

Behaviour:
- Reset (async, rst=0) sets:
  - lfsr=1, state=IDLE;
  - rnd=0, valid=0, busy=0, fallback=0;
  - last=0, have_last=0.
- Reset mid-draw aborts the draw; no valid is produced.
- LFSR runs free every cycle: if lfsr[0]=1 then lfsr <= (lfsr>>1)^TAPS, else lfsr <= lfsr>>1.
- load_seed has priority over advance: lfsr <= seed, or 1 if seed==0. It is legal while busy; the draw continues on the new sequence.
- Candidate = lfsr[OUT_W-1:0], using the pre-edge value.
- Accept rule: (lim_c==0 or cand<lim_c) and not (nr_c and have_last and cand==last).
- FSM, IDLE:
  - busy=0.
  - req=1 at edge E0 → capture lim_c=limite and nr_c=no_repeat; tries=0; state=DRAW; busy=1 after E0.
- FSM, DRAW, at each edge:
  - Accept → rnd<=cand, last<=cand, have_last<=1, valid<=1, fallback<=0; state=IDLE.
  - Reject and tries==MAX_TRIES-1 → fallback draw: rnd<=fb, last<=fb, have_last<=1, valid<=1, fallback<=1; state=IDLE.
  - Otherwise tries++.
- Fallback value: fb = have_last ? last+1 : 0, wrapped to 0 when fb>=lim_c (lim_c≠0) or when it overflows OUT_W. Limit-1 with no_repeat therefore yields 0 with fallback=1.
- Latency: minimum 1 edge after E0, maximum MAX_TRIES edges.
- valid is high exactly one cycle; busy falls on the same edge valid rises.
- req while busy is ignored and not queued.
- req held high re-arms on the first IDLE edge after valid, so back-to-back draws are spaced 2 edges minimum.
- limite/no_repeat changes during DRAW have no effect (captured values are used).

Test Plan:
1. Seed sequence, WIDTH=8, TAPS=B8:
   - rst released; load_seed=1, seed=0x00 at edge L (lfsr→0x01).
   - req=1, limite=0 at L+1 → valid at L+2, rnd=0 (0xB8[2:0]), fallback=0.
   - req at L+3 → valid at L+4, rnd=6 (0x2E).
2. Rejection:
   - Same seed load at L; req at L+2 with limite=3.
   - Candidates 4, 6, 7, 3 are rejected → valid at L+7, rnd=1 (0xE1). busy=1 from L+2 to L+7.
3. No-repeat fallback:
   - After an accepted rnd=0, req with limite=1, no_repeat=1.
   - After 16 edges: valid=1, fallback=1, rnd=0.
   - Repeat with limite=4, last=3 → fallback rnd=0 when all tries reject.
4. Ignored request and mid-draw seed:
   - req pulsed while busy → no extra valid.
   - load_seed seed=0x00 during DRAW → the next candidate comes from 0x01, result matches scenario 1 ordering.
5. Async reset mid-draw:
   - rst=0 between clock edges while busy=1 → busy, valid, rnd, fallback go 0 immediately, with no clock required.
   - After release, the first draw follows the lfsr=1 sequence.
6. Seed zero guard and full range:
   - load seed=0x00, limite=0 → never stuck; 20 consecutive draws produce non-constant values, all accepted with fallback=0.
